// File: rtl/hopfield_update_ctrl_pkg.sv
// Shared types and helpers for the Hopfield update sequencer.
package hopfield_update_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StRun,
    StWb,
    StSweep,
    StFin
  } upd_state_e;

  // Index width for n entries; never below 1 so a single-neuron net still has an address bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hopfield_update_ctrl.sv
// Sequencer for one shared neuron datapath: asynchronous in-order Hopfield sweeps until
// a sweep changes nothing or the sweep limit is reached.
module hopfield_update_ctrl
  import hopfield_update_ctrl_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned SIZE       = 32,
  parameter int unsigned MAX_SWEEPS = 16,
  parameter int unsigned IDXW       = clog2_min1(N),
  parameter int unsigned SWW        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE*N-1:0] s_init,
  output logic [IDXW-1:0]   w_addr,
  input  logic [SIZE*N-1:0] w_rdata,
  output logic              neu_en,
  output logic [SIZE*N-1:0] neu_scurr,
  output logic [SIZE*N-1:0] neu_w,
  input  logic [SIZE-1:0]   neu_snext,
  input  logic              neu_done,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [SWW-1:0]    sweep_count,
  output logic [SIZE*N-1:0] state_out
);

  upd_state_e            fsm_q;
  logic [IDXW-1:0]       idx_q;
  logic                  changed_q;
  logic [SIZE-1:0]       snext_q;
  logic [SIZE-1:0]       cur_entry;
  logic [SWW:0]          sweep_inc;
  logic                  sweep_limit;
  logic                  last_idx;

  always_comb begin
    cur_entry   = state_out[int'(idx_q)*SIZE +: SIZE];
    sweep_inc   = {1'b0, sweep_count} + {{SWW{1'b0}}, 1'b1};
    sweep_limit = (sweep_inc >= (SWW+1)'(MAX_SWEEPS));
    last_idx    = (idx_q == IDXW'(N-1));
  end

  // The address and the state vector seen by the neuron are registers, so both are glitch-free.
  assign w_addr    = idx_q;
  assign neu_scurr = state_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      idx_q       <= '0;
      changed_q   <= 1'b0;
      snext_q     <= '0;
      state_out   <= '0;
      neu_w       <= '0;
      neu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      sweep_count <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            state_out   <= s_init;
            idx_q       <= '0;
            sweep_count <= '0;
            changed_q   <= 1'b0;
            converged   <= 1'b0;
            busy        <= 1'b1;
            fsm_q       <= StFetch;
          end
        end
        StFetch: fsm_q <= StLatch;
        StLatch: begin
          neu_w  <= w_rdata;
          neu_en <= 1'b1;
          fsm_q  <= StRun;
        end
        StRun: begin
          if (neu_done) begin
            snext_q <= neu_snext;
            neu_en  <= 1'b0;
            fsm_q   <= StWb;
          end
        end
        StWb: begin
          if (snext_q != cur_entry) begin
            state_out[int'(idx_q)*SIZE +: SIZE] <= snext_q;
            changed_q                           <= 1'b1;
          end
          if (last_idx) begin
            fsm_q <= StSweep;
          end else begin
            idx_q <= idx_q + IDXW'(1);
            fsm_q <= StFetch;
          end
        end
        StSweep: begin
          sweep_count <= sweep_limit ? SWW'(MAX_SWEEPS) : sweep_inc[SWW-1:0];
          if (!changed_q) begin
            converged <= 1'b1;
            done      <= 1'b1;
            fsm_q     <= StFin;
          end else if (sweep_limit) begin
            converged <= 1'b0;
            done      <= 1'b1;
            fsm_q     <= StFin;
          end else begin
            idx_q     <= '0;
            changed_q <= 1'b0;
            fsm_q     <= StFetch;
          end
        end
        StFin: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          fsm_q <= StIdle;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hopfield_update_ctrl.sv
// Bench for hopfield_update_ctrl: behavioural neuron with random latency, 1-cycle row ROM,
// and a sweep-level reference model.
module tb_hopfield_update_ctrl;

  localparam int N    = 4;
  localparam int SIZE = 32;
  localparam int MAXS = 3;
  localparam int IDXW = 2;
  localparam int SWW  = 16;

  typedef int vec_t [N];
  typedef int mat_t [N][N];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [SIZE*N-1:0] s_init;
  logic [IDXW-1:0]   w_addr;
  logic [SIZE*N-1:0] w_rdata;
  logic              neu_en;
  logic [SIZE*N-1:0] neu_scurr;
  logic [SIZE*N-1:0] neu_w;
  logic [SIZE-1:0]   neu_snext;
  logic              neu_done;
  logic              busy;
  logic              done;
  logic              converged;
  logic [SWW-1:0]    sweep_count;
  logic [SIZE*N-1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SIZE*N-1:0] rom [N];
  mat_t wmat;

  hopfield_update_ctrl #(
    .N(N), .SIZE(SIZE), .MAX_SWEEPS(MAXS), .IDXW(IDXW), .SWW(SWW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_init(s_init), .w_addr(w_addr),
    .w_rdata(w_rdata), .neu_en(neu_en), .neu_scurr(neu_scurr), .neu_w(neu_w),
    .neu_snext(neu_snext), .neu_done(neu_done), .busy(busy), .done(done),
    .converged(converged), .sweep_count(sweep_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_rdata <= rom[w_addr];

  function automatic logic [SIZE-1:0] neuron_eval(input logic [SIZE*N-1:0] w,
                                                  input logic [SIZE*N-1:0] s);
    longint acc = 0;
    for (int k = 0; k < N; k++)
      acc += longint'($signed(w[k*SIZE +: SIZE])) * longint'($signed(s[k*SIZE +: SIZE]));
    if (acc > 0) return 32'd1;
    if (acc < 0) return 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  // Neuron: random latency, one done pulse per enable, rearms only after enable drops.
  logic nrn_pend, nrn_hold;
  int   nrn_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrn_pend <= 1'b0; nrn_hold <= 1'b0; nrn_cnt <= 0;
      neu_done <= 1'b0; neu_snext <= '0;
    end else begin
      neu_done <= 1'b0;
      if (nrn_hold) begin
        if (!neu_en) nrn_hold <= 1'b0;
      end else if (nrn_pend) begin
        if (nrn_cnt == 0) begin
          neu_done  <= 1'b1;
          neu_snext <= neuron_eval(neu_w, neu_scurr);
          nrn_pend  <= 1'b0;
          nrn_hold  <= 1'b1;
        end else begin
          nrn_cnt <= nrn_cnt - 1;
        end
      end else if (neu_en) begin
        nrn_pend <= 1'b1;
        nrn_cnt  <= int'($urandom_range(0, 3));
      end
    end
  end

  function automatic logic [SIZE*N-1:0] pack(input vec_t v);
    logic [SIZE*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*SIZE +: SIZE] = v[k];
    return r;
  endfunction

  task automatic load_w(input mat_t w);
    wmat = w;
    for (int i = 0; i < N; i++) begin
      vec_t row;
      for (int j = 0; j < N; j++) row[j] = w[i][j];
      rom[i] = pack(row);
    end
  endtask

  // Reference: plain asynchronous Hopfield iteration on integers.
  task automatic model(input vec_t s0, output vec_t s, output int sw, output bit conv);
    bit ch;
    s = s0; sw = 0; conv = 0;
    forever begin
      ch = 0;
      for (int i = 0; i < N; i++) begin
        int sum = 0;
        int sn;
        for (int j = 0; j < N; j++) sum += wmat[i][j] * s[j];
        sn = (sum > 0) ? 1 : (sum < 0) ? -1 : 0;
        if (sn != s[i]) begin s[i] = sn; ch = 1; end
      end
      sw++;
      if (!ch) begin conv = 1; break; end
      if (sw == MAXS) begin conv = 0; break; end
    end
  endtask

  task automatic pulse_start(input vec_t s0);
    @(negedge clk);
    s_init = pack(s0);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_run(output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (neu_en) begin ok = 1; break; end
    end
  endtask

  mat_t w_pat, w_negi, w_zero;
  vec_t p, p_bad, all_pos, all_neg, zeros;

  task automatic test_reset();
    n_checks++;
    if ({neu_en, busy, done, converged} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {neu_en, busy, done, converged});
    end
    n_checks++;
    if (sweep_count !== '0 || state_out !== '0 || neu_w !== '0 || w_addr !== '0) begin
      n_fail++; $display("FAIL reset_regs: sweep %0d state %h neu_w %h addr %0d want all 0",
                         sweep_count, state_out, neu_w, w_addr);
    end
  endtask

  task automatic test_stored_pattern();
    bit ok;
    load_w(w_pat);
    pulse_start(p);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stored_timeout: got no done want done"); end
    n_checks++;
    if (converged !== 1'b1 || sweep_count !== 16'd1 || state_out !== pack(p)) begin
      n_fail++; $display("FAIL stored_result: got conv %b sweeps %0d state %h want 1 1 %h",
                         converged, sweep_count, state_out, pack(p));
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || converged !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: got done %b busy %b conv %b want 0 0 1",
                         done, busy, converged);
    end
  endtask

  task automatic test_corrected();
    bit ok;
    load_w(w_pat);
    pulse_start(p_bad);
    wait_done(ok);
    n_checks++;
    if (!ok || converged !== 1'b1 || sweep_count !== 16'd2 || state_out !== pack(p)) begin
      n_fail++; $display("FAIL corrected: got ok %b conv %b sweeps %0d state %h want 1 1 2 %h",
                         ok, converged, sweep_count, state_out, pack(p));
    end
  endtask

  task automatic test_max_sweeps();
    bit ok;
    load_w(w_negi);
    pulse_start(all_pos);
    wait_done(ok);
    n_checks++;
    if (!ok || converged !== 1'b0 || sweep_count !== 16'(MAXS) || state_out !== pack(all_neg)) begin
      n_fail++; $display("FAIL max_sweeps: got ok %b conv %b sweeps %0d state %h want 1 0 %0d %h",
                         ok, converged, sweep_count, state_out, MAXS, pack(all_neg));
    end
  endtask

  task automatic test_zero_weights();
    bit ok;
    load_w(w_zero);
    pulse_start(all_pos);
    wait_done(ok);
    n_checks++;
    if (!ok || converged !== 1'b1 || sweep_count !== 16'd2 || state_out !== '0) begin
      n_fail++; $display("FAIL zero_w: got ok %b conv %b sweeps %0d state %h want 1 1 2 0",
                         ok, converged, sweep_count, state_out);
    end
  endtask

  task automatic test_random();
    int vals [4] = '{1, -1, 0, 7};
    for (int t = 0; t < 8; t++) begin
      mat_t w;
      vec_t s0, es;
      int   esw;
      bit   econv, ok;
      for (int i = 0; i < N; i++) begin
        s0[i] = vals[$urandom_range(0, 3)];
        for (int j = 0; j < N; j++) w[i][j] = int'($urandom_range(0, 4)) - 2;
      end
      load_w(w);
      model(s0, es, esw, econv);
      pulse_start(s0);
      wait_done(ok);
      n_checks++;
      if (!ok || converged !== econv || sweep_count !== 16'(esw) || state_out !== pack(es)) begin
        n_fail++; $display("FAIL random_%0d: got ok %b conv %b sweeps %0d state %h want 1 %b %0d %h",
                           t, ok, converged, sweep_count, state_out, econv, esw, pack(es));
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    load_w(w_pat);
    pulse_start(p_bad);
    wait_run(ok);
    s_init = pack(all_neg);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || converged !== 1'b1 || sweep_count !== 16'd2 || state_out !== pack(p)) begin
      n_fail++; $display("FAIL start_busy: got ok %b conv %b sweeps %0d state %h want 1 1 2 %h",
                         ok, converged, sweep_count, state_out, pack(p));
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, saw_done;
    load_w(w_negi);
    pulse_start(all_pos);
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL run_reach: got no neu_en want neu_en"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({neu_en, busy, done, converged} !== 4'b0 || sweep_count !== '0 || state_out !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got en %b busy %b done %b conv %b sweeps %0d state %h want 0",
                         neu_en, busy, done, converged, sweep_count, state_out);
    end
    saw_done = 0;
    repeat (3) begin @(negedge clk); saw_done |= done; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); saw_done |= done; end
    n_checks++;
    if (saw_done || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_done_after_reset: got done %b busy %b want 0 0", saw_done, busy);
    end
    load_w(w_pat);
    pulse_start(p_bad);
    wait_done(ok);
    n_checks++;
    if (!ok || converged !== 1'b1 || sweep_count !== 16'd2 || state_out !== pack(p)) begin
      n_fail++; $display("FAIL after_reset_run: got ok %b conv %b sweeps %0d state %h want 1 1 2 %h",
                         ok, converged, sweep_count, state_out, pack(p));
    end
  endtask

  initial begin
    p       = '{1, -1, 1, -1};
    p_bad   = '{-1, -1, 1, -1};
    all_pos = '{1, 1, 1, 1};
    all_neg = '{-1, -1, -1, -1};
    zeros   = '{0, 0, 0, 0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_pat[i][j]  = (i == j) ? 0 : p[i] * p[j];
        w_negi[i][j] = (i == j) ? -1 : 0;
        w_zero[i][j] = zeros[j];
      end
    load_w(w_zero);
    rst_n  = 1'b0;
    start  = 1'b0;
    s_init = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_stored_pattern();
    test_corrected();
    test_max_sweeps();
    test_zero_weights();
    test_random();
    test_start_while_busy();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
